// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer and its combinational ALU core:
// widths, instruction field positions, opcodes, FSM states and compare tags.
package alu_seq_pkg;

  localparam int DATA_W  = 4;
  localparam int OP_W    = 3;
  localparam int IDX_W   = 2;
  localparam int REG_N   = 4;
  localparam int INSTR_W = 10;
  localparam int CNT_W   = 8;

  // Instruction layout: {ld, op[2:0], rd[1:0], rs[1:0], rt[1:0]}
  localparam int LD_BIT = 9;
  localparam int OP_HI  = 8;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 2;
  localparam int RT_HI  = 1;
  localparam int RT_LO  = 0;

  // Upper three result bits that tag the compare operations
  localparam logic [2:0] LT_TAG = 3'b101;
  localparam logic [2:0] EQ_TAG = 3'b111;

  typedef enum logic [OP_W-1:0] {
    OP_SUB  = 3'd0,
    OP_ADD  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_ROTR = 3'd4,
    OP_ROTL = 3'd5,
    OP_LT   = 3'd6,
    OP_EQ   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Load-immediate value carried in the rs/rt fields
  function automatic logic [DATA_W-1:0] imm_of(input logic [INSTR_W-1:0] instr);
    return {instr[RS_HI:RS_LO], instr[RT_HI:RT_LO]};
  endfunction

endpackage

// File: rtl/alu4_exec.sv
// Combinational 4-bit, eight-operation ALU. All arithmetic wraps modulo 16;
// the compare ops return a tagged nibble so the display can tell them apart.
module alu4_exec
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  // Unsigned wraparound arithmetic on the 4-bit operands
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return x + y;
  endfunction

  function automatic logic [DATA_W-1:0] wrap_sub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return x - y;
  endfunction

  // Select the operation result
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_SUB:  result = wrap_sub(a, b);
      OP_ADD:  result = wrap_add(a, b);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_ROTR: result = {b[0], b[DATA_W-1:1]};
      OP_ROTL: result = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_LT:   result = {LT_TAG, (a < b)};
      OP_EQ:   result = {EQ_TAG, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequenced front end for the 4-bit ALU: accepts one instruction at a time,
// reads operands from a 4x4 register file, computes, and hands the result
// out over valid/ready. The register write happens when the result is taken,
// so the next instruction always sees the updated file.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_rd,
  input  logic [IDX_W-1:0]   dbg_idx,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [CNT_W-1:0]   retired
);

  state_e              state;
  state_e              state_nxt;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   rf [REG_N];

  logic                accept;
  logic                retire;
  logic                ld_q;
  logic [OP_W-1:0]     op_q;
  logic [IDX_W-1:0]    rd_q;
  logic [IDX_W-1:0]    rs_q;
  logic [IDX_W-1:0]    rt_q;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   exec_res;

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  assign ld_q = instr_q[LD_BIT];
  assign op_q = instr_q[OP_HI:OP_LO];
  assign rd_q = instr_q[RD_HI:RD_LO];
  assign rs_q = instr_q[RS_HI:RS_LO];
  assign rt_q = instr_q[RT_HI:RT_LO];

  // Operands come from the file as it stands during EXEC, so an instruction
  // whose rd matches rs/rt still reads the pre-write values.
  assign opa = rf[rs_q];
  assign opb = rf[rt_q];

  alu4_exec u_alu (
    .a      (opa),
    .b      (opb),
    .op     (op_q),
    .result (alu_res)
  );

  assign exec_res = ld_q ? imm_of(instr_q) : alu_res;

  assign dbg_data = rf[dbg_idx];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch; only written on an accepted handshake
  always_ff @(posedge clk) begin
    if (accept) instr_q <= in_instr;
  end

  // Result registers, loaded once in EXEC and held through backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_rd   <= '0;
    end else if (state == ST_EXEC) begin
      out_data <= exec_res;
      out_rd   <= rd_q;
    end
  end

  // Register file write-back on result acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (retire) begin
      rf[out_rd] <= out_data;
    end
  end

  // Retired-instruction counter; wraps silently
  always_ff @(posedge clk) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

endmodule
